// File: rtl/uart_txfifo.sv
// uart_txfifo: CPU-side TX byte FIFO with a drain FSM feeding the uart.
// Optional drain-complete interrupt: define UART_TXFIFO_IRQ_EN.
module uart_txfifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq,
    output logic [2:0]  uart_a,
    output logic [31:0] uart_d,
    output logic        uart_we,
    input  logic [31:0] uart_spo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POLL = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_t        state;
    state_t        state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          idle_seen;

    logic cpu_fwd;
    logic owned;
    logic empty;
    logic full;
    logic push_ok;
    logic flush;
    logic send_fire;
    logic idle_set;

    assign cpu_fwd   = (a == 3'd1) | ((a == 3'd0) & ~we);
    assign owned     = ~cpu_fwd;
    assign empty     = (level == '0);
    assign full      = (level == FULL_LVL);
    assign flush     = we & (a == 3'd4);
    assign push_ok   = we & (a == 3'd0) & ~full & ~flush;
    assign send_fire = owned & (state == SEND);
    assign idle_set  = owned & (state != SEND) & uart_spo[0];

    // Uart mux and drain FSM next state; the drainer freezes on CPU-owned cycles
    always_comb begin
        state_nx = state;
        uart_a   = 3'd2;
        uart_d   = '0;
        uart_we  = 1'b0;
        if (cpu_fwd) begin
            uart_a  = a;
            uart_d  = d;
            uart_we = we & (a == 3'd1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) state_nx = POLL;
                end
                POLL: begin
                    if (uart_spo[0]) state_nx = SEND;
                end
                SEND: begin
                    uart_a  = 3'd0;
                    uart_d  = {mem[rd_ptr], 24'b0};
                    uart_we = 1'b1;
                    if ((level > 1) || push_ok) state_nx = POLL;
                    else state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
            if (flush) state_nx = IDLE;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // Byte storage; contents need no reset, pointers gate validity
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= d[31:24];
    end

    // Pointers and level; flush overrides both push and pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (send_fire) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, send_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Remembers that the uart reported done since the last byte went out
    always_ff @(posedge clk) begin
        if (rst) idle_seen <= 1'b1;
        else if (send_fire) idle_seen <= 1'b0;
        else if (idle_set) idle_seen <= 1'b1;
    end

    // CPU read mux
    always_comb begin
        spo = '0;
        unique case (a)
            3'd0, 3'd1: spo = uart_spo;
            3'd2:       spo = {31'b0, empty & idle_seen};
            3'd3:       spo = 32'(level);
            default:    spo = '0;
        endcase
    end

`ifdef UART_TXFIFO_IRQ_EN
    logic irq_q;
    logic sent_any;
    logic irq_set;
    logic irq_clr;

    assign irq_clr = we & (a == 3'd5);
    assign irq_set = (send_fire & (level == 1) & ~push_ok)
                   | (idle_set & ~idle_seen & empty & sent_any);

    // Tracks whether any byte has been transmitted since reset
    always_ff @(posedge clk) begin
        if (rst) sent_any <= 1'b0;
        else if (send_fire) sent_any <= 1'b1;
    end

    // Sticky interrupt; software clear wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else if (irq_clr) irq_q <= 1'b0;
        else if (irq_set) irq_q <= 1'b1;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txfifo.sv
// tb_uart_txfifo: randomized + directed bench with a queue-based reference
// model of the byte stream and a behavioural uart status model.
module tb_uart_txfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        irq;
    logic [2:0]  uart_a;
    logic [31:0] uart_d;
    logic        uart_we;
    logic [31:0] uart_spo;

    int   errs   = 0;
    int   checks = 0;
    int   n_sent = 0;
    int   busy_cnt;
    logic hold   = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_txfifo dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
        .uart_a(uart_a), .uart_d(uart_d), .uart_we(uart_we),
        .uart_spo(uart_spo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Uart model: busy for a few cycles after each data write
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (uart_we && uart_a == 3'd0) busy_cnt <= 1 + int'($urandom % 5);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    assign uart_spo = (uart_a == 3'd2) ? {31'b0, (busy_cnt == 0) && !hold} :
                      (uart_a == 3'd0) ? 32'h0000_005A : 32'h0000_0003;

    // Reference model: FIFO as a queue, updated once per cycle mid-cycle
    always @(negedge clk) begin
        int pre;
        if (!rst) begin
            pre = exp_q.size();
            if (a == 3'd3 && !we) chk("lvl_model", spo, 32'(pre));
            if (uart_we && uart_a == 3'd0) begin
                n_sent++;
                if (pre == 0) chk("send_when_empty", 32'd1, 32'd0);
                else begin
                    chk("send_byte", 32'(uart_d[31:24]), 32'(exp_q.pop_front()));
                    chk("send_ready", 32'(busy_cnt), 32'd0);
                end
            end
            if (we && a == 3'd4) exp_q.delete();
            else if (we && a == 3'd0 && pre < 16) exp_q.push_back(d[31:24]);
        end
    end

    task automatic cyc(input logic [2:0] aa, input logic [31:0] dd,
                       input logic ww);
        @(posedge clk);
        #1;
        a  = aa;
        d  = dd;
        we = ww;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        cyc(3'd2, 32'd0, 1'b0);
        k = 0;
        while (k < budget && !(exp_q.size() == 0 && busy_cnt == 0)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_rd2(input string tag, input int budget);
        int k;
        cyc(3'd2, 32'd0, 1'b0);
        @(negedge clk);
        k = 0;
        while (k < budget && spo[0] !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        chk(tag, spo, 32'd1);
    endtask

    task automatic rd_level(input string tag, input int exp);
        cyc(3'd3, 32'd0, 1'b0);
        @(negedge clk);
        chk(tag, spo, 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int viol;
        int op;
        rst = 1'b1;
        a = 3'd2;
        d = '0;
        we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_uart_a", 32'(uart_a), 32'd2);
        chk("rst_uart_we", 32'(uart_we), 32'd0);
        chk("rst_uart_d", uart_d, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rd2", spo, 32'd1);
        rd_level("rst_level", 0);

        // 1: three back-to-back pushes
        base = n_sent;
        cyc(3'd0, 32'h4100_0000, 1'b1);
        cyc(3'd0, 32'h4200_0000, 1'b1);
        cyc(3'd0, 32'h4300_0000, 1'b1);
        wait_drain("t1_drain", 200);
        chk("t1_count", 32'(n_sent - base), 32'd3);
        wait_rd2("t1_rd2", 50);

        // 6: interrupt after drain and software clear
        repeat (3) cyc(3'd2, 32'd0, 1'b0);
        @(negedge clk);
`ifdef UART_TXFIFO_IRQ_EN
        chk("t6_irq_set", 32'(irq), 32'd1);
`else
        chk("t6_irq_off", 32'(irq), 32'd0);
`endif
        cyc(3'd5, 32'd0, 1'b1);
        cyc(3'd2, 32'd0, 1'b0);
        @(negedge clk);
        chk("t6_irq_clr", 32'(irq), 32'd0);

        // 2: overfill with uart busy
        hold = 1'b1;
        base = n_sent;
        for (int i = 0; i < 17; i++) cyc(3'd0, {8'(8'h10 + i), 24'h0}, 1'b1);
        rd_level("t2_full", 16);
        chk("t2_no_send", 32'(n_sent - base), 32'd0);
        hold = 1'b0;
        wait_drain("t2_drain", 600);
        chk("t2_count", 32'(n_sent - base), 32'd16);

        // 3: CPU holds uart via addr-0 reads
        hold = 1'b1;
        base = n_sent;
        cyc(3'd0, 32'hAA00_0000, 1'b1);
        cyc(3'd0, 32'hBB00_0000, 1'b1);
        cyc(3'd2, 32'd0, 1'b0);
        cyc(3'd2, 32'd0, 1'b0);
        hold = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(3'd0, 32'd0, 1'b0);
            @(negedge clk);
            if (uart_we || uart_a != 3'd0 || spo != 32'h5A) viol++;
        end
        chk("t3_stall", 32'(viol), 32'd0);
        chk("t3_no_send", 32'(n_sent - base), 32'd0);
        wait_drain("t3_drain", 200);
        chk("t3_count", 32'(n_sent - base), 32'd2);

        // 4: flush while a send is pending
        hold = 1'b1;
        for (int i = 0; i < 5; i++) cyc(3'd0, {8'(8'h60 + i), 24'h0}, 1'b1);
        cyc(3'd2, 32'd0, 1'b0);
        hold = 1'b0;
        base = n_sent;
        cyc(3'd4, 32'd0, 1'b1);
        repeat (30) cyc(3'd2, 32'd0, 1'b0);
        chk("t4_sends", 32'(n_sent - base), 32'd1);
        rd_level("t4_level", 0);
        wait_rd2("t4_rd2", 50);

        // 5: rx write collides with SEND
        hold = 1'b1;
        base = n_sent;
        cyc(3'd0, 32'hC100_0000, 1'b1);
        cyc(3'd0, 32'hC200_0000, 1'b1);
        cyc(3'd2, 32'd0, 1'b0);
        cyc(3'd2, 32'd0, 1'b0);
        hold = 1'b0;
        cyc(3'd1, 32'h0000_1234, 1'b1);
        @(negedge clk);
        chk("t5_fwd", {uart_a, uart_we, uart_d[27:0]}, {3'd1, 1'b1, 28'h1234});
        cyc(3'd2, 32'd0, 1'b0);
        @(negedge clk);
        chk("t5_defer", {uart_a, uart_we, uart_d[31:24], 20'h0},
                        {3'd0, 1'b1, 8'hC1, 20'h0});
        wait_drain("t5_drain", 200);
        chk("t5_count", 32'(n_sent - base), 32'd2);

        // Random mix against the queue model
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom % 10);
            unique case (op)
                0, 1, 2, 3: cyc(3'd0, $urandom, 1'b1);
                4: cyc(3'd0, 32'd0, 1'b0);
                5: cyc(3'd3, 32'd0, 1'b0);
                6: cyc(3'd1, $urandom, 1'b1);
                7: cyc(3'd2, 32'd0, 1'b0);
                8: cyc(3'd5, 32'd0, 1'b1);
                default: begin
                    if ($urandom % 4 == 0) cyc(3'd4, 32'd0, 1'b1);
                    else cyc(3'd6, 32'd0, 1'b0);
                end
            endcase
        end
        wait_drain("rand_drain", 1000);
        rd_level("rand_level", 0);
        wait_rd2("rand_rd2", 50);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
